counter_multi: RTL and testbench

- Multi-channel programmable counter/timer; parametrised successor of the single 8-bit `counter`.
- Each of CHANNELS independent channels has its own:
  - period and control byte;
  - up/down direction;
  - auto-reload or one-shot mode;
  - power-of-two prescaler.
- Emits per-channel terminal-count pulses and sticky done flags; used as the timer bank feeding interrupt/event logic.

---
 rtl/counter_multi.sv | 115 +++++++++++
 tb/tb_counter_multi.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_multi.sv
// Multi-channel programmable counter/timer bank: per-channel period, direction,
// auto-reload/one-shot and power-of-two prescaler, with tc pulses and sticky done flags.
module counter_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       clear,
    input  logic [CHANNELS*WIDTH-1:0] period,
    input  logic [CHANNELS*8-1:0]     control,
    output logic [CHANNELS*WIDTH-1:0] value,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       done
);

    function automatic logic [2:0] ps_limit(input logic [1:0] ps);
        logic [2:0] lim;
        case (ps)
            2'd0:    lim = 3'd0;
            2'd1:    lim = 3'd1;
            2'd2:    lim = 3'd3;
            default: lim = 3'd7;
        endcase
        return lim;
    endfunction

    genvar g;
    for (g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] w_period;
        logic [WIDTH-1:0] r_value;
        logic [WIDTH-1:0] w_value_nxt;
        logic [2:0]       r_pscnt;
        logic [2:0]       w_pscnt_nxt;
        logic [2:0]       w_limit;
        logic             r_halted;
        logic             w_halted_nxt;
        logic             r_tc;
        logic             w_tc_nxt;
        logic             r_done;
        logic             w_done_nxt;
        logic             w_reload;
        logic             w_dir;
        logic             w_tick;
        logic             w_terminal;
        logic             w_unused_rsvd;

        assign w_period      = period[g*WIDTH +: WIDTH];
        assign w_reload      = control[g*8];
        assign w_dir         = control[g*8+1];
        assign w_limit       = ps_limit(control[g*8+2 +: 2]);
        assign w_unused_rsvd = ^control[g*8+4 +: 4];

        assign w_tick     = enable[g] & ~r_halted & (r_pscnt == w_limit);
        // Up mode uses >= so lowering the period below the count terminates on the next tick.
        assign w_terminal = w_dir ? (r_value == '0) : (r_value >= w_period);

        // Next-state selection: clear beats tick, tick beats plain prescaler advance.
        always_comb begin
            w_value_nxt  = r_value;
            w_pscnt_nxt  = r_pscnt;
            w_halted_nxt = r_halted;
            w_done_nxt   = r_done;
            w_tc_nxt     = 1'b0;
            if (clear[g]) begin
                w_value_nxt  = w_dir ? w_period : '0;
                w_pscnt_nxt  = 3'd0;
                w_halted_nxt = 1'b0;
                w_done_nxt   = 1'b0;
            end else if (w_tick) begin
                w_pscnt_nxt = 3'd0;
                if (w_terminal) begin
                    w_tc_nxt = 1'b1;
                    if (w_reload) begin
                        w_value_nxt = w_dir ? w_period : '0;
                    end else begin
                        w_halted_nxt = 1'b1;
                        w_done_nxt   = 1'b1;
                    end
                end else if (w_dir) begin
                    w_value_nxt = r_value - WIDTH'(1);
                end else begin
                    w_value_nxt = r_value + WIDTH'(1);
                end
            end else if (enable[g] && !r_halted) begin
                w_pscnt_nxt = r_pscnt + 3'd1;
            end else begin
                w_pscnt_nxt = r_pscnt;
            end
        end

        // Channel state registers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_value  <= '0;
                r_pscnt  <= 3'd0;
                r_halted <= 1'b0;
                r_tc     <= 1'b0;
                r_done   <= 1'b0;
            end else begin
                r_value  <= w_value_nxt;
                r_pscnt  <= w_pscnt_nxt;
                r_halted <= w_halted_nxt;
                r_tc     <= w_tc_nxt;
                r_done   <= w_done_nxt;
            end
        end

        assign value[g*WIDTH +: WIDTH] = r_value;
        assign tc[g]                   = r_tc;
        assign done[g]                 = r_done;
    end

endmodule

// File: tb/tb_counter_multi.sv
// Scoreboard bench for counter_multi: stimulus pushes hand-derived expectations,
// a monitor pops and compares them at the falling edge (or on demand).
module tb_counter_multi;
    localparam int W = 8;
    localparam int N = 4;

    logic           clk;
    logic           reset;
    logic [N-1:0]   enable;
    logic [N-1:0]   clear;
    logic [N*W-1:0] period;
    logic [N*8-1:0] control;
    logic [N*W-1:0] value;
    logic [N-1:0]   tc;
    logic [N-1:0]   done;

    typedef struct {
        int cyc;
        int ch;
        int val;
        bit tc;
        bit dn;
        int id;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   total   = 0;
    int   bad     = 0;
    int   tid     = 0;
    bit   end_req = 1'b0;
    event ev_sample;

    counter_multi #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .period(period), .control(control),
        .value(value), .tc(tc), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due by now.
    always @(negedge clk or ev_sample) begin : mon
        exp_t       e;
        logic [W-1:0] av;
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            e  = q.pop_front();
            av = value[e.ch*W +: W];
            total++;
            if (e.cyc != cyc || av !== W'(e.val) || tc[e.ch] !== e.tc || done[e.ch] !== e.dn) begin
                bad++;
                $display("FAIL t%0d_ch%0d cyc=%0d(due %0d): got value=%0h tc=%0b done=%0b, want value=%0h tc=%0b done=%0b",
                         e.id, e.ch, cyc, e.cyc, av, tc[e.ch], done[e.ch], W'(e.val), e.tc, e.dn);
            end
        end
        if (end_req && q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: got %0d unchecked expectations, want 0", q.size());
            q.delete();
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input int dc, input int ch, input int v, input bit t, input bit d);
        exp_t e;
        e.cyc = cyc + dc;
        e.ch  = ch;
        e.val = v;
        e.tc  = t;
        e.dn  = d;
        e.id  = tid;
        q.push_back(e);
    endtask

    task automatic cfg(input int ch, input int p, input int c);
        period[ch*W +: W]  = W'(p);
        control[ch*8 +: 8] = 8'(c);
    endtask

    initial begin
        reset  = 1'b0;
        enable = '0;
        clear  = '0;
        period = '0;
        control = '0;
        cfg(0, 8'h0A, 8'h01);
        cfg(1, 8'h05, 8'h06);
        cfg(2, 8'h0A, 8'h05);
        cfg(3, 8'h0A, 8'h01);

        // reset state
        tid = 0;
        for (int c = 0; c < N; c++) chk(1, c, 0, 1'b0, 1'b0);
        step();

        // ch0 up auto-reload, period 10: 11-cycle cycle
        tid = 1;
        reset  = 1'b1;
        enable = 4'b0001;
        for (int n = 1; n <= 24; n++) begin
            chk(1, 0, n % 11, (n % 11) == 0, 1'b0);
            step();
        end
        enable = 4'b0000;

        // ch1 one-shot down, PS=1, period 5
        tid = 2;
        clear = 4'b0010;
        chk(1, 1, 5, 1'b0, 1'b0);
        step();
        clear  = 4'b0000;
        enable = 4'b0010;
        for (int m = 1; m <= 16; m++) begin
            if (m <= 11)      chk(1, 1, 5 - m / 2, 1'b0, 1'b0);
            else if (m == 12) chk(1, 1, 0, 1'b1, 1'b1);
            else              chk(1, 1, 0, 1'b0, 1'b1);
            step();
        end
        clear = 4'b0010;
        chk(1, 1, 5, 1'b0, 1'b0);
        step();
        clear  = 4'b0000;
        enable = 4'b0000;
        chk(1, 1, 5, 1'b0, 1'b0);
        step();

        // ch2 enable gating and clear priority over tick (PS=1)
        tid = 3;
        enable = 4'b0100;
        chk(1, 2, 0, 1'b0, 1'b0); step();
        chk(1, 2, 1, 1'b0, 1'b0); step();
        chk(1, 2, 1, 1'b0, 1'b0); step();
        enable = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            chk(1, 2, 1, 1'b0, 1'b0);
            step();
        end
        enable = 4'b0100;
        chk(1, 2, 2, 1'b0, 1'b0); step();
        chk(1, 2, 2, 1'b0, 1'b0); step();
        clear = 4'b0100;
        chk(1, 2, 0, 1'b0, 1'b0); step();
        clear = 4'b0000;
        chk(1, 2, 0, 1'b0, 1'b0); step();
        chk(1, 2, 1, 1'b0, 1'b0); step();
        enable = 4'b0000;

        // ch3 period lowered mid-count
        tid = 4;
        enable = 4'b1000;
        for (int m = 1; m <= 8; m++) begin
            chk(1, 3, m, 1'b0, 1'b0);
            step();
        end
        cfg(3, 8'h03, 8'h01);
        chk(1, 3, 0, 1'b1, 1'b0); step();
        chk(1, 3, 1, 1'b0, 1'b0); step();
        chk(1, 3, 2, 1'b0, 1'b0); step();
        chk(1, 3, 3, 1'b0, 1'b0); step();
        chk(1, 3, 0, 1'b1, 1'b0); step();
        enable = 4'b0000;

        // independence: periods 0x00/0x01/0x0A/0xFF, mixed modes
        tid = 5;
        cfg(0, 8'h00, 8'h01);
        cfg(1, 8'h01, 8'h03);
        cfg(2, 8'h0A, 8'h0A);
        cfg(3, 8'hFF, 8'h00);
        clear = 4'b1111;
        chk(1, 0, 0, 1'b0, 1'b0);
        chk(1, 1, 1, 1'b0, 1'b0);
        chk(1, 2, 10, 1'b0, 1'b0);
        chk(1, 3, 0, 1'b0, 1'b0);
        step();
        clear  = 4'b0000;
        enable = 4'b1111;
        for (int m = 1; m <= 20; m++) begin
            chk(1, 0, 0, 1'b1, 1'b0);
            chk(1, 1, (m % 2 == 0) ? 1 : 0, (m % 2) == 0, 1'b0);
            chk(1, 2, 10 - m / 4, 1'b0, 1'b0);
            chk(1, 3, m, 1'b0, 1'b0);
            step();
        end

        // async reset between edges
        tid = 6;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        for (int c = 0; c < N; c++) chk(0, c, 0, 1'b0, 1'b0);
        ->ev_sample;
        step();
        reset  = 1'b1;
        enable = 4'b0000;
        for (int c = 0; c < N; c++) chk(1, c, 0, 1'b0, 1'b0);
        step();
        enable = 4'b1000;
        chk(1, 3, 1, 1'b0, 1'b0);
        chk(1, 2, 0, 1'b0, 1'b0);
        step();
        chk(1, 3, 2, 1'b0, 1'b0);
        step();

        end_req = 1'b1;
        @(negedge clk);
        #1;
        ->ev_sample;
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
